// File: rtl/lc3_pkg.sv
// Shared types and helpers for the branch resolve path.
// Condition-code bit positions match the {n,z,p} ordering of IR[11:9].
package lc3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } br_state_t;

  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

endpackage

// File: rtl/br_resolve_unit_if.sv
// Request (IR/PC/CC) and response (BEN/target) handshakes of the branch resolve unit.
// slave is the unit itself; master is the control FSM / PC-load side.
interface br_resolve_unit_if;
  logic        br_valid;
  logic        br_ready;
  logic [15:0] IR;
  logic [15:0] PC;
  logic        n;
  logic        z;
  logic        p;
  logic        res_valid;
  logic        res_ready;
  logic        ben;
  logic [15:0] target;

  modport master (
    output br_valid, IR, PC, n, z, p, res_ready,
    input  br_ready, res_valid, ben, target
  );

  modport slave (
    input  br_valid, IR, PC, n, z, p, res_ready,
    output br_ready, res_valid, ben, target
  );
endinterface

// File: rtl/br_sat_counter.sv
// Saturating event counter; synchronous clear takes priority over increment.
// Holds at all-ones instead of wrapping.
module br_sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/br_resolve_unit.sv
// Resolves BR instructions against the n/z/p flags and returns BEN + target PC.
// Three-state FSM (IDLE/EVAL/RESP): one branch per 3 cycles, response held until consumed.
module br_resolve_unit
  import lc3_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  br_resolve_unit_if.slave  bus,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  nottaken_cnt
);

  br_state_t   state_q, state_d;
  logic [2:0]  cond_q, cond_d;
  logic [8:0]  off9_q, off9_d;
  logic [15:0] pc_q, pc_d;
  logic [2:0]  nzp_q, nzp_d;
  logic        ben_q, ben_d;
  logic [15:0] target_q, target_d;

  logic        br_ready;
  logic        res_valid;
  logic        inc_taken;
  logic        inc_nottaken;

  always_comb begin
    state_d      = state_q;
    cond_d       = cond_q;
    off9_d       = off9_q;
    pc_d         = pc_q;
    nzp_d        = nzp_q;
    ben_d        = ben_q;
    target_d     = target_q;
    br_ready     = 1'b0;
    res_valid    = 1'b0;
    inc_taken    = 1'b0;
    inc_nottaken = 1'b0;

    case (state_q)
      IDLE: begin
        br_ready = 1'b1;
        // Operands are frozen here; later input changes cannot leak into the result.
        if (bus.br_valid) begin
          cond_d       = bus.IR[11:9];
          off9_d       = bus.IR[8:0];
          pc_d         = bus.PC;
          nzp_d[CC_N]  = bus.n;
          nzp_d[CC_Z]  = bus.z;
          nzp_d[CC_P]  = bus.p;
          state_d      = EVAL;
        end
      end
      EVAL: begin
        ben_d    = |(cond_q & nzp_q);
        target_d = ben_d ? (pc_q + sext9(off9_q)) : pc_q;
        state_d  = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (bus.res_ready) begin
          inc_taken    = ben_q;
          inc_nottaken = ~ben_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cond_q   <= '0;
      off9_q   <= '0;
      pc_q     <= '0;
      nzp_q    <= '0;
      ben_q    <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cond_q   <= cond_d;
      off9_q   <= off9_d;
      pc_q     <= pc_d;
      nzp_q    <= nzp_d;
      ben_q    <= ben_d;
      target_q <= target_d;
    end
  end

  assign bus.br_ready  = br_ready;
  assign bus.res_valid = res_valid;
  assign bus.ben       = ben_q;
  assign bus.target    = target_q;

  br_sat_counter #(.W(CNT_W)) u_taken_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (inc_taken),
    .clr   (cnt_clr),
    .count (taken_cnt)
  );

  br_sat_counter #(.W(CNT_W)) u_nottaken_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (inc_nottaken),
    .clr   (cnt_clr),
    .count (nottaken_cnt)
  );

endmodule

// File: tb/tb_br_resolve_unit.sv
// Bench for br_resolve_unit: a 16-bit and a 2-bit-counter instance run in lockstep
// on identical stimulus, checked against an arithmetic reference model.
module tb_br_resolve_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        br_valid, res_ready, cnt_clr;
  logic        n, z, p;
  logic [15:0] ir, pc;

  logic [15:0] taken_cnt, nottaken_cnt;
  logic [1:0]  taken2, nottaken2;

  int checks = 0;
  int errors = 0;
  int m_taken = 0;
  int m_nt    = 0;

  always #5 Clk = ~Clk;

  br_resolve_unit_if bif ();
  br_resolve_unit_if bif2 ();

  assign bif.br_valid  = br_valid;
  assign bif.IR        = ir;
  assign bif.PC        = pc;
  assign bif.n         = n;
  assign bif.z         = z;
  assign bif.p         = p;
  assign bif.res_ready = res_ready;

  assign bif2.br_valid  = br_valid;
  assign bif2.IR        = ir;
  assign bif2.PC        = pc;
  assign bif2.n         = n;
  assign bif2.z         = z;
  assign bif2.p         = p;
  assign bif2.res_ready = res_ready;

  br_resolve_unit #(.CNT_W(16)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .bus          (bif.slave),
    .cnt_clr      (cnt_clr),
    .taken_cnt    (taken_cnt),
    .nottaken_cnt (nottaken_cnt)
  );

  br_resolve_unit #(.CNT_W(2)) dut2 (
    .Clk          (Clk),
    .Reset        (Reset),
    .bus          (bif2.slave),
    .cnt_clr      (cnt_clr),
    .taken_cnt    (taken2),
    .nottaken_cnt (nottaken2)
  );

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
    logic [2:0]  nzp;
    logic        ben;
    logic [15:0] target;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk_cnts(input string tag);
    chk({tag, "_taken16"},    taken_cnt,    sat(m_taken, 65535));
    chk({tag, "_nottaken16"}, nottaken_cnt, sat(m_nt, 65535));
    chk({tag, "_taken2"},     taken2,       sat(m_taken, 3));
    chk({tag, "_nottaken2"},  nottaken2,    sat(m_nt, 3));
  endtask

  // Reference: a flag matches when its IR[11:9] selector bit is set; offset is a signed 9-bit number.
  task automatic ref_resolve(input logic [15:0] ir_v, input logic [15:0] pc_v,
                             input logic [2:0] nzp_v, output logic b, output logic [15:0] t);
    int off;
    b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (ir_v[9 + k] == 1'b1 && nzp_v[k] == 1'b1) b = 1'b1;
    end
    off = int'(ir_v[8:0]);
    if (off > 255) off = off - 512;
    t = b ? 16'((int'(pc_v) + off + 65536) % 65536) : pc_v;
  endtask

  task automatic scramble_inputs();
    br_valid  = 1'($urandom_range(0, 1));
    ir        = 16'($urandom);
    pc        = 16'($urandom);
    {n, z, p} = 3'($urandom);
  endtask

  // Entered 1 time unit after a rising edge with the DUT in IDLE; leaves it the same way.
  task automatic run_branch(input logic [15:0] ir_v, input logic [15:0] pc_v, input logic [2:0] nzp_v,
                            input logic exp_b, input logic [15:0] exp_t, input int hold, input logic clr_at_hs);
    chk("idle_br_ready", bif.br_ready, 1);
    br_valid  = 1'b1;
    ir        = ir_v;
    pc        = pc_v;
    {n, z, p} = nzp_v;
    @(posedge Clk); #1;
    scramble_inputs();
    chk("eval_res_valid", bif.res_valid, 0);
    chk("eval_br_ready",  bif.br_ready,  0);
    @(posedge Clk); #1;
    chk("resp_res_valid", bif.res_valid, 1);
    chk("resp_ben",       bif.ben,       exp_b);
    chk("resp_target",    bif.target,    exp_t);
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      scramble_inputs();
      @(posedge Clk); #1;
      chk("hold_res_valid", bif.res_valid, 1);
      chk("hold_br_ready",  bif.br_ready,  0);
      chk("hold_ben",       bif.ben,       exp_b);
      chk("hold_target",    bif.target,    exp_t);
    end
    res_ready = 1'b1;
    br_valid  = 1'b0;
    cnt_clr   = clr_at_hs;
    @(posedge Clk); #1;
    res_ready = 1'b0;
    cnt_clr   = 1'b0;
    if (clr_at_hs) begin
      m_taken = 0;
      m_nt    = 0;
    end else if (exp_b) begin
      m_taken++;
    end else begin
      m_nt++;
    end
    chk("done_res_valid", bif.res_valid, 0);
    chk_cnts("done");
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_br_ready"},  bif.br_ready,  1);
    chk({tag, "_res_valid"}, bif.res_valid, 0);
    chk({tag, "_ben"},       bif.ben,       0);
    chk({tag, "_target"},    bif.target,    0);
    chk({tag, "_taken"},     taken_cnt,     0);
    chk({tag, "_nottaken"},  nottaken_cnt,  0);
    chk({tag, "_taken2"},    taken2,        0);
  endtask

  task automatic reset_pulse_and_verify(input string tag);
    #2 Reset = 1'b1;
    #1 chk_reset_state(tag);
    m_taken = 0;
    m_nt    = 0;
    @(posedge Clk); #1;
    Reset     = 1'b0;
    br_valid  = 1'b0;
    res_ready = 1'b1;
    repeat (4) begin
      @(posedge Clk); #1;
    end
    res_ready = 1'b0;
    chk({tag, "_post_res_valid"}, bif.res_valid, 0);
    chk_cnts({tag, "_post"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        b;
    logic [15:0] t;
    logic [15:0] r_ir, r_pc;
    logic [2:0]  r_nzp;

    tbl[0] = '{ir: 16'h0E05, pc: 16'h3001, nzp: 3'b010, ben: 1'b1, target: 16'h3006};
    tbl[1] = '{ir: 16'h0805, pc: 16'h3001, nzp: 3'b001, ben: 1'b0, target: 16'h3001};
    tbl[2] = '{ir: 16'h05FF, pc: 16'h0000, nzp: 3'b010, ben: 1'b1, target: 16'hFFFF};
    tbl[3] = '{ir: 16'h0401, pc: 16'hFFFF, nzp: 3'b010, ben: 1'b1, target: 16'h0000};
    tbl[4] = '{ir: 16'h0005, pc: 16'h4000, nzp: 3'b111, ben: 1'b0, target: 16'h4000};
    tbl[5] = '{ir: 16'h0E05, pc: 16'h1234, nzp: 3'b000, ben: 1'b0, target: 16'h1234};
    tbl[6] = '{ir: 16'h0300, pc: 16'h3000, nzp: 3'b001, ben: 1'b1, target: 16'h2F00};

    Reset     = 1'b1;
    br_valid  = 1'b0;
    res_ready = 1'b0;
    cnt_clr   = 1'b0;
    ir        = '0;
    pc        = '0;
    {n, z, p} = 3'b000;
    repeat (2) @(posedge Clk);
    #1 chk_reset_state("in_reset");
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk_reset_state("after_reset");

    // Directed vectors; the last one holds the response for 5 cycles under input churn.
    for (int i = 0; i < 7; i++) begin
      run_branch(tbl[i].ir, tbl[i].pc, tbl[i].nzp, tbl[i].ben, tbl[i].target,
                 (i == 6) ? 5 : 0, 1'b0);
    end
    chk("sat_taken2_after_4", taken2, 3);

    for (int i = 0; i < 30; i++) begin
      r_ir  = 16'($urandom);
      r_pc  = 16'($urandom);
      r_nzp = 3'($urandom);
      ref_resolve(r_ir, r_pc, r_nzp, b, t);
      run_branch(r_ir, r_pc, r_nzp, b, t, $urandom_range(0, 3), 1'b0);
    end

    run_branch(16'h0E01, 16'h0100, 3'b100, 1'b1, 16'h0101, 0, 1'b1);
    chk("clr_coincident_taken", taken_cnt, 0);
    run_branch(16'h0805, 16'h2000, 3'b001, 1'b0, 16'h2000, 1, 1'b0);
    cnt_clr = 1'b1;
    @(posedge Clk); #1;
    cnt_clr = 1'b0;
    m_taken = 0;
    m_nt    = 0;
    chk_cnts("idle_clr");

    run_branch(16'h0E05, 16'h3001, 3'b010, 1'b1, 16'h3006, 0, 1'b0);
    br_valid  = 1'b1;
    ir        = 16'h0E05;
    pc        = 16'h3001;
    {n, z, p} = 3'b010;
    @(posedge Clk); #1;
    br_valid = 1'b0;
    chk("pre_rst_eval_res_valid", bif.res_valid, 0);
    reset_pulse_and_verify("rst_eval");

    run_branch(16'h0805, 16'h3001, 3'b001, 1'b0, 16'h3001, 0, 1'b0);
    br_valid  = 1'b1;
    ir        = 16'h0E05;
    pc        = 16'h3001;
    {n, z, p} = 3'b010;
    @(posedge Clk); #1;
    br_valid = 1'b0;
    @(posedge Clk); #1;
    chk("pre_rst_resp_res_valid", bif.res_valid, 1);
    reset_pulse_and_verify("rst_resp");

    run_branch(16'h0E05, 16'h3001, 3'b010, 1'b1, 16'h3006, 0, 1'b0);
    chk("post_reset_taken_is_1", taken_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
